// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store buffer draining (addr, data) pairs to data memory
// Optional load forwarding is built when STORE_FWD_EN is defined.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_ready,
  output logic                       mem_wr_en,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ack,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come from the occupancy count only, so ready never depends on mem_ack.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = st_valid && !w_full;
  assign w_pop   = !w_empty && mem_ack;

  assign st_ready  = !w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign mem_wr_en = !w_empty;
  assign mem_addr  = w_empty ? '0 : r_addr[r_rd_ptr];
  assign mem_wdata = w_empty ? '0 : r_data[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage needs no reset: it is only observed through count-qualified paths.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_data[r_wr_ptr] <= st_data;
    end
  end

`ifdef STORE_FWD_EN
  logic          w_ld_hit;
  logic [DW-1:0] w_ld_data;
  logic [PW-1:0] w_idx;

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == ld_addr)) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data[w_idx];
      end
    end
  end

  assign ld_hit  = w_ld_hit;
  assign ld_data = w_ld_data;
`else
  logic w_unused_ld;

  assign w_unused_ld = ^ld_addr;
  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
`endif

endmodule
